// File: rtl/rf_write_sched_pkg.sv
// rf_sched_pkg: shared types and default geometry for the register file write scheduler
package rf_sched_pkg;
  typedef enum logic {ST_ARB, ST_CLEAR} rfs_state_t;
  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_NREGS = 32;
  typedef logic [RF_DW-1:0] word_t;
endpackage

// File: rtl/rf_write_sched_if.sv
// rf_write_sched_if: requester bus, clear control and register file write port
interface rf_write_sched_if #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 32
) ();
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_wsel;
  logic [NREQ*DW-1:0] req_wdat;
  logic [NREQ-1:0]    gnt;
  logic               clr_req;
  logic               clr_busy;
  logic               rf_WEN;
  logic [AW-1:0]      rf_wsel;
  logic [DW-1:0]      rf_wdat;
  modport master (output req, req_wsel, req_wdat, clr_req,
                  input gnt, clr_busy, rf_WEN, rf_wsel, rf_wdat);
  modport slave (input req, req_wsel, req_wdat, clr_req,
                 output gnt, clr_busy, rf_WEN, rf_wsel, rf_wdat);
endinterface

// File: rtl/rf_write_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr+1 mod N
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        idx = PW'((int'(ptr) + k) % N);
        gnt[(int'(ptr) + k) % N] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rf_write_sched.sv
// rf_write_sched: round-robin sharing of the register file write port; the zero-clear
// sequencer is built only with RFSCHED_CLEAR_EN defined.
module rf_write_sched
  import rf_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int NREGS = RF_NREGS,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
) (
  input logic CLK,
  input logic nRST,
  rf_write_sched_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win;
  logic [NREQ-1:0] arb_gnt;
  logic            any;
  logic            arb_en;
  logic [AW-1:0]   win_wsel;
  logic [DW-1:0]   win_wdat;
  rr_arbiter #(.N(NREQ)) u_arb (
    .req(bus.req),
    .ptr(rr_ptr),
    .gnt(arb_gnt),
    .idx(win),
    .any(any)
  );
  assign win_wsel = bus.req_wsel[int'(win)*AW +: AW];
  assign win_wdat = bus.req_wdat[int'(win)*DW +: DW];
`ifdef RFSCHED_CLEAR_EN
  rfs_state_t    state;
  logic [AW-1:0] clr_idx;
  // a clear request steals the cycle it arrives in, so nothing is granted then
  assign arb_en       = nRST && state == ST_ARB && !bus.clr_req;
  assign bus.clr_busy = state == ST_CLEAR;
`else
  assign arb_en       = nRST;
  assign bus.clr_busy = 1'b0;
`endif
  assign bus.gnt = arb_en ? arb_gnt : '0;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr      <= PW'(NREQ-1);
      bus.rf_WEN  <= 1'b0;
      bus.rf_wsel <= '0;
      bus.rf_wdat <= '0;
`ifdef RFSCHED_CLEAR_EN
      state       <= ST_CLEAR;
      clr_idx     <= AW'(1);
`endif
    end
`ifdef RFSCHED_CLEAR_EN
    else if (state == ST_CLEAR) begin
      bus.rf_WEN  <= 1'b1;
      bus.rf_wsel <= clr_idx;
      bus.rf_wdat <= '0;
      state       <= clr_idx == AW'(NREGS-1) ? ST_ARB : ST_CLEAR;
      clr_idx     <= clr_idx == AW'(NREGS-1) ? AW'(1) : clr_idx + AW'(1);
    end
    else if (bus.clr_req) begin
      bus.rf_WEN <= 1'b0;
      state      <= ST_CLEAR;
      clr_idx    <= AW'(1);
    end
`endif
    else begin
      // register 0 is hardwired zero: accept the grant but suppress the write
      bus.rf_WEN <= any && win_wsel != '0;
      if (any) begin
        rr_ptr      <= win;
        bus.rf_wsel <= win_wsel;
        bus.rf_wdat <= win_wdat;
      end
    end
  end
endmodule
